// File: rtl/clock_set_ctrl_if.sv
// Keypad / clock-datapath bundle for the time-setting controller.
// slave = controller side, master = datapath/keypad side.
interface clock_set_ctrl_if;
   logic       key_mode;
   logic       key_inc;
   logic [4:0] cur_hr;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;
   logic       set_en;
   logic [1:0] edit_field;
   logic [4:0] set_hr;
   logic [5:0] set_min;
   logic [5:0] set_sec;
   logic       load;
   logic       blink;

   modport slave (
      input  key_mode, key_inc, cur_hr, cur_min, cur_sec,
      output set_en, edit_field, set_hr, set_min, set_sec, load, blink
   );

   modport master (
      output key_mode, key_inc, cur_hr, cur_min, cur_sec,
      input  set_en, edit_field, set_hr, set_min, set_sec, load, blink
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounces mode/inc keys, walks RUN->HR->MIN->SEC
// over shadow registers, auto-repeats held inc, blinks the edited field,
// abandons an idle edit, and commits with a one-cycle load strobe.
module clock_set_ctrl #(
   parameter int DEB_MS     = 20,
   parameter int LONG_MS    = 600,
   parameter int REPEAT_MS  = 200,
   parameter int TIMEOUT_MS = 10000,
   parameter int BLINK_MS   = 250
) (
   input logic              clk_1khz,
   input logic              rst,
   clock_set_ctrl_if.slave  bus
);
   localparam int DW = $clog2(DEB_MS + 1);
   localparam int HW = $clog2(LONG_MS + 1);
   localparam int TW = $clog2(TIMEOUT_MS + 1);
   localparam int BW = $clog2(BLINK_MS + 1);

   // encodings double as the edit_field output value
   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;

   // key index 0 = mode, 1 = inc
   logic [1:0]         w_key_raw;
   logic [1:0]         r_sync1, r_sync2, r_deb, r_deb_q, r_press;
   logic [1:0][DW-1:0] r_deb_cnt;

   state_t      r_state;
   logic        r_set_en, r_load, r_blink;
   logic [4:0]  r_set_hr;
   logic [5:0]  r_set_min, r_set_sec;
   logic [HW-1:0] r_hold;
   logic [TW-1:0] r_to;
   logic [BW-1:0] r_blk_cnt;

   logic w_in_set, w_mode_ev, w_inc_ev, w_rep, w_bump, w_tout;

   assign w_key_raw = {bus.key_inc, bus.key_mode};

   // synchronise, debounce (DEB_MS consecutive disagreeing samples) and edge-detect both keys
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_deb     <= '0;
         r_deb_q   <= '0;
         r_press   <= '0;
         r_deb_cnt <= '0;
      end else begin
         r_sync1 <= w_key_raw;
         r_sync2 <= r_sync1;
         r_deb_q <= r_deb;
         r_press <= r_deb & ~r_deb_q;
         for (int k = 0; k < 2; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_deb_cnt[k] <= '0;
            end else if (r_deb_cnt[k] == DW'(DEB_MS - 1)) begin
               r_deb[k]     <= ~r_deb[k];
               r_deb_cnt[k] <= '0;
            end else begin
               r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
            end
         end
      end
   end

   // event priority: mode > increment/repeat > timeout
   assign w_in_set  = (r_state != RUN);
   assign w_mode_ev = r_press[0];
   assign w_inc_ev  = r_press[1] & ~w_mode_ev & w_in_set;
   assign w_rep     = w_in_set & r_deb[1] & ~w_mode_ev & (r_hold == HW'(LONG_MS));
   assign w_bump    = w_inc_ev | w_rep;
   assign w_tout    = w_in_set & ~w_mode_ev & ~w_bump & (r_to == TW'(TIMEOUT_MS - 1));

   // hold counter: starts at the inc press, first repeat at LONG_MS, then every REPEAT_MS
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst)
         r_hold <= '0;
      else if (!w_in_set || !r_deb[1] || w_mode_ev || w_tout)
         r_hold <= '0;
      else if (w_rep)
         r_hold <= HW'(LONG_MS - REPEAT_MS + 1);
      else if (w_inc_ev || r_hold != '0)
         r_hold <= r_hold + 1'b1;
   end

   // inactivity counter, restarted by any press or repeat
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst)
         r_to <= '0;
      else if (!w_in_set || w_mode_ev || w_bump || w_tout)
         r_to <= '0;
      else
         r_to <= r_to + 1'b1;
   end

   // blink: steady on in RUN, restarted on entry and increment, toggles every BLINK_MS
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         r_blk_cnt <= '0;
         r_blink   <= 1'b1;
      end else if (!w_in_set || w_mode_ev || w_bump || w_tout) begin
         r_blk_cnt <= '0;
         r_blink   <= 1'b1;
      end else if (r_blk_cnt == BW'(BLINK_MS - 1)) begin
         r_blk_cnt <= '0;
         r_blink   <= ~r_blink;
      end else begin
         r_blk_cnt <= r_blk_cnt + 1'b1;
      end
   end

   // mode FSM with registered outputs and shadow time registers
   always_ff @(posedge clk_1khz or posedge rst) begin
      if (rst) begin
         r_state   <= RUN;
         r_set_en  <= 1'b0;
         r_load    <= 1'b0;
         r_set_hr  <= '0;
         r_set_min <= '0;
         r_set_sec <= '0;
      end else begin
         r_load <= 1'b0;
         if (w_mode_ev) begin
            case (r_state)
               RUN: begin
                  r_state   <= SET_HR;
                  r_set_en  <= 1'b1;
                  r_set_hr  <= bus.cur_hr;
                  r_set_min <= bus.cur_min;
                  r_set_sec <= bus.cur_sec;
               end
               SET_HR:  r_state <= SET_MIN;
               SET_MIN: r_state <= SET_SEC;
               default: begin
                  r_state  <= RUN;
                  r_set_en <= 1'b0;
                  r_load   <= 1'b1;
               end
            endcase
         end else if (w_tout) begin
            r_state  <= RUN;
            r_set_en <= 1'b0;
         end else if (w_bump) begin
            case (r_state)
               SET_HR:  r_set_hr  <= (r_set_hr  >= 5'd23) ? 5'd0 : r_set_hr  + 5'd1;
               SET_MIN: r_set_min <= (r_set_min >= 6'd59) ? 6'd0 : r_set_min + 6'd1;
               SET_SEC: r_set_sec <= (r_set_sec >= 6'd59) ? 6'd0 : r_set_sec + 6'd1;
               default: ;
            endcase
         end
      end
   end

   assign bus.set_en     = r_set_en;
   assign bus.edit_field = r_state;
   assign bus.set_hr     = r_set_hr;
   assign bus.set_min    = r_set_min;
   assign bus.set_sec    = r_set_sec;
   assign bus.load       = r_load;
   assign bus.blink      = r_blink;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table for press sequences plus
// hand sequences for auto-repeat, load strobe, timeout, blink and reset.
module tb_clock_set_ctrl;
   logic clk_1khz = 1'b0;
   logic rst      = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   load_cnt = 0;
   int   base;

   clock_set_ctrl_if bus();

   clock_set_ctrl dut (
      .clk_1khz (clk_1khz),
      .rst      (rst),
      .bus      (bus)
   );

   always #1 clk_1khz = ~clk_1khz;

   // count load cycles as seen between edges
   always @(negedge clk_1khz) if (bus.load) load_cnt++;

   typedef struct {
      logic m, i;
      int   len;
      int   chr, cmin, csec;
      int   en, fld, hr, mn, sc;
   } vec_t;

   vec_t tv[15];

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_1khz);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic press(input logic m, input logic i, input int len);
      bus.key_mode = m;
      bus.key_inc  = i;
      cyc(len);
      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
   endtask

   task automatic chk_all(input string p, input int en, input int fld, input int hr,
                          input int mn, input int sc, input int ld, input int bl);
      chk({p, "_en"},    int'(bus.set_en), en);
      chk({p, "_fld"},   int'(bus.edit_field), fld);
      chk({p, "_hr"},    int'(bus.set_hr), hr);
      chk({p, "_min"},   int'(bus.set_min), mn);
      chk({p, "_sec"},   int'(bus.set_sec), sc);
      chk({p, "_load"},  int'(bus.load), ld);
      chk({p, "_blink"}, int'(bus.blink), bl);
   endtask

   initial begin
      //          m  i  len  cur hh mm ss  en fld hr mn sc
      tv[0]  = '{1, 0, 30, 12, 34, 56, 1, 1, 12, 34, 56};
      tv[1]  = '{0, 1, 15, 12, 34, 56, 1, 1, 12, 34, 56};
      tv[2]  = '{0, 1, 15, 12, 34, 56, 1, 1, 12, 34, 56};
      tv[3]  = '{0, 1, 30, 12, 34, 56, 1, 1, 13, 34, 56};
      tv[4]  = '{1, 0, 30, 12, 34, 56, 1, 2, 13, 34, 56};
      tv[5]  = '{0, 1, 30, 12, 34, 56, 1, 2, 13, 35, 56};
      tv[6]  = '{1, 0, 30, 12, 34, 56, 1, 3, 13, 35, 56};
      tv[7]  = '{0, 1, 30, 12, 34, 56, 1, 3, 13, 35, 57};
      tv[8]  = '{1, 0, 30, 12, 34, 56, 0, 0, 13, 35, 57};
      tv[9]  = '{0, 1, 30, 22, 58, 59, 0, 0, 13, 35, 57};
      tv[10] = '{1, 0, 30, 22, 58, 59, 1, 1, 22, 58, 59};
      tv[11] = '{0, 1, 30, 22, 58, 59, 1, 1, 23, 58, 59};
      tv[12] = '{0, 1, 30, 22, 58, 59, 1, 1,  0, 58, 59};
      tv[13] = '{0, 1, 30, 22, 58, 59, 1, 1,  1, 58, 59};
      tv[14] = '{1, 0, 30, 22, 58, 59, 1, 2,  1, 58, 59};

      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
      bus.cur_hr   = 5'd12;
      bus.cur_min  = 6'd34;
      bus.cur_sec  = 6'd56;

      // reset state
      cyc(3);
      chk_all("rst", 0, 0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      cyc(5);

      // first mode press: nothing before DEB_MS+4, SET_HR exactly then
      bus.key_mode = 1'b1;
      cyc(23);
      chk("lat_pre_en", int'(bus.set_en), 0);
      cyc(1);
      chk("lat_en", int'(bus.set_en), 1);
      chk("lat_fld", int'(bus.edit_field), 1);
      cyc(6);
      bus.key_mode = 1'b0;
      cyc(40);
      // return to RUN (SET_HR -> MIN -> SEC -> RUN) before the table
      for (int k = 0; k < 3; k++) begin
         press(1'b1, 1'b0, 30);
         cyc(40);
      end
      chk_all("pre", 0, 0, 12, 34, 56, 0, 1);

      // vector table
      for (int v = 0; v < 15; v++) begin
         bus.cur_hr  = 5'(tv[v].chr);
         bus.cur_min = 6'(tv[v].cmin);
         bus.cur_sec = 6'(tv[v].csec);
         press(tv[v].m, tv[v].i, tv[v].len);
         cyc(40);
         chk_all($sformatf("v%0d", v), tv[v].en, tv[v].fld, tv[v].hr, tv[v].mn, tv[v].sc, 0, 1);
      end

      // auto-repeat in SET_MIN from 58: press + repeats at +600..+1400
      bus.key_inc = 1'b1;
      cyc(24);
      chk("rep_press", int'(bus.set_min), 59);
      cyc(599);
      chk("rep_pre_long", int'(bus.set_min), 59);
      cyc(1);
      chk("rep_first", int'(bus.set_min), 0);
      cyc(200);
      chk("rep_second", int'(bus.set_min), 1);
      cyc(676);
      bus.key_inc = 1'b0;
      cyc(100);
      chk("rep_final", int'(bus.set_min), 4);
      chk("rep_fld", int'(bus.edit_field), 2);

      // SET_MIN -> SET_SEC, then commit: load exactly one cycle
      press(1'b1, 1'b0, 30);
      cyc(40);
      chk("sec_fld", int'(bus.edit_field), 3);
      base = load_cnt;
      bus.key_mode = 1'b1;
      cyc(23);
      chk("ld_pre", int'(bus.load), 0);
      cyc(1);
      chk("ld_pulse", int'(bus.load), 1);
      chk("ld_en", int'(bus.set_en), 0);
      chk("ld_fld", int'(bus.edit_field), 0);
      cyc(1);
      chk("ld_post", int'(bus.load), 0);
      cyc(5);
      bus.key_mode = 1'b0;
      cyc(40);
      chk("ld_count", load_cnt - base, 1);
      chk_all("ld_shadow", 0, 0, 1, 4, 59, 0, 1);

      // timeout from SET_SEC with no keys: RUN at entry+10000, no load
      for (int k = 0; k < 2; k++) begin
         press(1'b1, 1'b0, 30);
         cyc(40);
      end
      base = load_cnt;
      press(1'b1, 1'b0, 30);          // entry edge E at +24, now E+6
      cyc(9993);
      chk("to_pre_fld", int'(bus.edit_field), 3);
      cyc(1);
      chk("to_fld", int'(bus.edit_field), 0);
      chk("to_en", int'(bus.set_en), 0);
      chk("to_sec", int'(bus.set_sec), 59);
      cyc(10);
      chk("to_noload", load_cnt - base, 0);

      // timeout pushed back by an inc processed at E+9000
      for (int k = 0; k < 2; k++) begin
         press(1'b1, 1'b0, 30);
         cyc(40);
      end
      base = load_cnt;
      press(1'b1, 1'b0, 30);          // now E+6
      cyc(40);                        // E+46
      cyc(8930);                      // E+8976
      press(1'b0, 1'b1, 30);          // processed at E+9000, now E+9006
      chk("to2_inc", int'(bus.set_sec), 0);
      cyc(9993);                      // E+18999
      chk("to2_pre_fld", int'(bus.edit_field), 3);
      cyc(1);
      chk("to2_fld", int'(bus.edit_field), 0);
      chk("to2_noload", load_cnt - base, 0);

      // blink period after entering SET_HR
      press(1'b1, 1'b0, 30);          // E+6
      cyc(243);
      chk("blk_on", int'(bus.blink), 1);
      cyc(1);
      chk("blk_off", int'(bus.blink), 0);
      cyc(250);
      chk("blk_back", int'(bus.blink), 1);

      // mode and inc together: mode wins, hours untouched
      press(1'b1, 1'b1, 30);
      cyc(40);
      chk("both_fld", int'(bus.edit_field), 2);
      chk("both_hr", int'(bus.set_hr), 22);
      chk("both_min", int'(bus.set_min), 58);

      // reset mid-edit: immediate reset values, no load afterwards
      base = load_cnt;
      rst = 1'b1;
      #0.5;
      chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 1);
      cyc(3);
      rst = 1'b0;
      cyc(50);
      chk("mid_rst_fld", int'(bus.edit_field), 0);
      chk("mid_rst_noload", load_cnt - base, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
